instr_fetch: RTL and testbench

// - Instruction fetch stage directly downstream of the PIC24 program counter.
// - Takes the even 24-bit PC address and reads the instruction from program memory over a
//   16-bit bus: low word at PC, then upper byte at PC+1.
// - Assembles the 24-bit instruction, buffers it in a small prefetch FIFO and hands it to
//   the decoder with a valid/ready handshake.
// - Pulses the PC increment request once per completed fetch.

---
 rtl/instr_fetch.sv | 232 +++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage that sits directly behind the PIC24 program counter.
// For every instruction it issues two 16-bit program memory reads: the low word
// at the even PC, then the upper byte at PC+1. It assembles the 24-bit
// instruction {upper byte, low word}, buffers it in a small prefetch FIFO and
// presents it to the decoder with a valid/ready handshake. pcinc_o pulses once
// per completed fetch so the PC can advance.
//
// Parameters
//   DEPTH      prefetch FIFO entries (power of two, >= 2)
//   PC_SETTLE  idle cycles after a pcinc_o pulse or flush release before the
//              next fetch may start
//
// Ports
//   clk_i          in   1   clock, rising edge
//   rst_ni         in   1   asynchronous active-low reset
//   pc_addr_i      in   24  current PC (bit 0 and bit 23 always 0)
//   pcinc_o        out  1   one-cycle PC increment request
//   flush_i        in   1   branch / PC load in progress, discard prefetch
//   pmem_req_o     out  1   program memory read request, held until ack
//   pmem_addr_o    out  24  program memory word address
//   pmem_ack_i     in   1   read complete, pmem_rdata_i valid this cycle
//   pmem_rdata_i   in   16  read data
//   instr_valid_o  out  1   FIFO head valid
//   instr_ready_i  in   1   decoder accepts the head
//   instr_o        out  24  head instruction {upper byte, low word}
//   instr_addr_o   out  24  PC the head instruction was fetched from
//   fetch_cnt_o    out  16  fetched-instruction counter
//
// Build option
//   FETCH_PERF_EN  when defined, fetch_cnt_o counts FIFO pushes (saturating,
//                  cleared only by reset); otherwise it is tied to zero.
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned PC_SETTLE = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] pc_addr_i,
    output logic        pcinc_o,
    input  logic        flush_i,
    output logic        pmem_req_o,
    output logic [23:0] pmem_addr_o,
    input  logic        pmem_ack_i,
    input  logic [15:0] pmem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [23:0] instr_o,
    output logic [23:0] instr_addr_o,
    output logic [15:0] fetch_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = (PC_SETTLE < 1) ? 1 : $clog2(PC_SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StReqLo, StReqHi, StSettle} state_e;

    state_e          state_q, state_d;
    logic [23:0]     pc_q;
    logic [15:0]     lo_q;
    logic            abort_q;
    logic [SW-1:0]   settle_q;
    logic            pcinc_q;

    logic [23:0]     fifo_instr [DEPTH];
    logic [23:0]     fifo_addr  [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            pc_capture, lo_capture, push, pop;
    logic            settle_load, settle_dec, aborted;

    // The upper byte of the PC+1 read is the phantom byte and is never used.
    logic [7:0]      unused_phantom;
    assign unused_phantom = pmem_rdata_i[15:8];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the edge regardless of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    // A fetch is aborted by a flush seen at any point while its reads are
    // outstanding; the pending read still completes before moving on.
    assign aborted = abort_q | flush_i;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pmem_req_o  = 1'b0;
        pmem_addr_o = '0;
        pc_capture  = 1'b0;
        lo_capture  = 1'b0;
        push        = 1'b0;
        settle_load = 1'b0;
        settle_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d     = StSettle;
                    settle_load = 1'b1;
                end else if (settle_q == '0 && count_q < CW'(DEPTH)) begin
                    state_d    = StReqLo;
                    pc_capture = 1'b1;
                end
            end
            StReqLo: begin
                pmem_req_o  = 1'b1;
                pmem_addr_o = pc_q;
                if (pmem_ack_i) begin
                    if (aborted) begin
                        state_d     = StSettle;
                        settle_load = 1'b1;
                    end else begin
                        state_d    = StReqHi;
                        lo_capture = 1'b1;
                    end
                end
            end
            StReqHi: begin
                pmem_req_o  = 1'b1;
                pmem_addr_o = pc_q + 24'd1;
                if (pmem_ack_i) begin
                    state_d     = StSettle;
                    settle_load = 1'b1;
                    push        = !aborted;
                end
            end
            StSettle: begin
                // A flush keeps re-arming the wait so the full settle time is
                // counted from the cycle the flush is released.
                if (flush_i)              settle_load = 1'b1;
                else if (settle_q == '0)  state_d     = StIdle;
                else                      settle_dec  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Fetch bookkeeping: captured PC, low word, abort flag, settle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= '0;
            lo_q     <= '0;
            abort_q  <= 1'b0;
            settle_q <= '0;
            pcinc_q  <= 1'b0;
        end else begin
            if (pc_capture) pc_q <= pc_addr_i;
            if (lo_capture) lo_q <= pmem_rdata_i;

            if (pmem_req_o && pmem_ack_i && state_d == StSettle) abort_q <= 1'b0;
            else if (pmem_req_o && flush_i)                      abort_q <= 1'b1;

            if (settle_load)     settle_q <= SW'(PC_SETTLE);
            else if (settle_dec) settle_q <= settle_q - SW'(1);

            pcinc_q <= push;
        end
    end

    assign pcinc_o = pcinc_q;

    // ------------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------------
    assign pop = (count_q != '0) && instr_ready_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH by themselves.
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: the storage array is deliberately left without reset; the count
    // and pointers define which entries are meaningful, and the head outputs
    // are gated to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= {pmem_rdata_i[7:0], lo_q};
            fifo_addr[wr_ptr_q]  <= pc_q;
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr_q] : '0;
    assign instr_addr_o  = instr_valid_o ? fifo_addr[rd_ptr_q]  : '0;

    // ------------------------------------------------------------------------
    // Optional fetch counter
    // ------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          fetch_cnt_q <= '0;
        else if (push && fetch_cnt_q != '1)   fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end

    assign fetch_cnt_o = fetch_cnt_q;
`else
    assign fetch_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. The bench plays the PC, program memory
// and decoder. A transaction-level model tracks which fetches must land in the
// prefetch buffer (a queue of expected {instruction, address}), when pcinc_o
// must pulse, the minimum idle gap before a new fetch, and the fetch counter.
// Directed phases cover the documented scenarios, then a random phase mixes
// ack latency, stray acks, decoder back-pressure and flushes.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int DEPTH     = 2;
    localparam int PC_SETTLE = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [23:0] pc_addr_i;
    logic        pcinc_o;
    logic        flush_i;
    logic        pmem_req_o;
    logic [23:0] pmem_addr_o;
    logic        pmem_ack_i;
    logic [15:0] pmem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [23:0] instr_o;
    logic [23:0] instr_addr_o;
    logic [15:0] fetch_cnt_o;

    instr_fetch #(.DEPTH(DEPTH), .PC_SETTLE(PC_SETTLE)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_addr_i     (pc_addr_i),
        .pcinc_o       (pcinc_o),
        .flush_i       (flush_i),
        .pmem_req_o    (pmem_req_o),
        .pmem_addr_o   (pmem_addr_o),
        .pmem_ack_i    (pmem_ack_i),
        .pmem_rdata_i  (pmem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Program memory contents (filled lazily with random words)
    // ------------------------------------------------------------------------
    logic [15:0] mem [logic [23:0]];

    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    // ------------------------------------------------------------------------
    // Model state and stimulus knobs
    // ------------------------------------------------------------------------
    typedef struct {
        logic [23:0] instr;
        logic [23:0] addr;
    } ent_t;

    ent_t        q[$];
    logic [23:0] pc_m = '0;
    logic [23:0] fetch_pc, last_lo;
    logic [23:0] fetch_instr;
    logic [23:0] addr_prev;
    logic [15:0] cnt_exp = '0;
    bit          req_prev, ack_prev, expect_hi, aborted, pcinc_exp;
    int          cyc = 0, last_end = -100, prev_size = 0, wait_cnt = 0;
    int          pcinc_seen = 0, fetches = 0, pushes = 0, pp_events = 0;
    int          flush_left = 0;

    int          lat_knob   = 0;     // <0: random 0..3
    int          ready_mode = 0;     // 0 never, 1 always, 2 only on push, 3 random
    bit          rand_mode  = 0;
    bit          flush_knob = 0;
    bit          exact_gap  = 0;
    logic [23:0] new_pc     = '0;

    // One clock cycle: observe outputs, choose this cycle's inputs, advance the model.
    task automatic step();
        bit          cont, new_req, is_hi, fl, ack, push, pop, rdy;
        int          sz;
        logic [15:0] w_lo, w_hi;
        ent_t        e;

        @(negedge clk_i);
        sz = q.size();

        check("pcinc", 32'(pcinc_o), 32'(pcinc_exp));
        pcinc_exp = 0;
        if (pcinc_o) pcinc_seen++;

        check("valid", 32'(instr_valid_o), 32'(sz != 0));
        if (sz != 0) begin
            check("instr", 32'(instr_o), 32'(q[0].instr));
            check("instr_addr", 32'(instr_addr_o), 32'(q[0].addr));
        end
        check("fetch_cnt", 32'(fetch_cnt_o), 32'(cnt_exp));

        cont    = req_prev && !ack_prev;
        new_req = pmem_req_o && !cont;
        is_hi   = expect_hi;
        if (cont) begin
            check("req_hold", 32'(pmem_req_o), 32'd1);
            check("addr_hold", 32'(pmem_addr_o), 32'(addr_prev));
        end else if (expect_hi) begin
            check("hi_follows", 32'(pmem_req_o), 32'd1);
        end

        if (new_req) begin
            if (expect_hi) begin
                check("addr_hi", 32'(pmem_addr_o), 32'(fetch_pc + 24'd1));
            end else begin
                check("addr_lo", 32'(pmem_addr_o), 32'(pc_m));
                check("settle_gap", 32'(cyc >= last_end + PC_SETTLE + 3), 32'd1);
                if (exact_gap) check("throughput", 32'(cyc - last_end), 32'(PC_SETTLE + 3));
                check("fifo_room", 32'(prev_size < DEPTH), 32'd1);
                fetch_pc    = pc_m;
                w_lo        = mem_rd(pc_m);
                w_hi        = mem_rd(pc_m + 24'd1);
                fetch_instr = {w_hi[7:0], w_lo};
                aborted     = 0;
                last_lo     = pc_m;
                fetches++;
            end
        end

        // PC behaviour: advance on pcinc, reload while a flush is in progress.
        if (pcinc_o) pc_m = pc_m + 24'd2;
        fl = flush_knob;
        if (rand_mode) begin
            if (flush_left > 0) begin
                flush_left--;
                fl = 1;
            end else if ($urandom_range(0, 59) == 0) begin
                flush_left = $urandom_range(0, 3);
                fl = 1;
            end
        end
        if (fl) pc_m = rand_mode ? {1'b0, 22'($urandom), 1'b0} : new_pc;
        pc_addr_i = pc_m;
        flush_i   = fl;

        // Memory responder.
        if (pmem_req_o) begin
            if (new_req) wait_cnt = (lat_knob < 0) ? $urandom_range(0, 3) : lat_knob;
            ack = (wait_cnt == 0);
            if (!ack) wait_cnt--;
        end else begin
            ack = rand_mode && ($urandom_range(0, 3) == 0);
        end
        pmem_ack_i   = ack;
        pmem_rdata_i = (pmem_req_o && ack) ? mem_rd(pmem_addr_o) : 16'($urandom);

        push = pmem_req_o && ack && is_hi && !(aborted || fl);

        // Decoder.
        case (ready_mode)
            0:       rdy = 0;
            1:       rdy = 1;
            2:       rdy = push;
            default: rdy = 1'($urandom);
        endcase
        instr_ready_i = rdy;
        pop = (sz != 0) && rdy && !fl;

        // Model update.
        if (pmem_req_o && fl) aborted = 1;
        if (pmem_req_o && ack) begin
            if (is_hi) begin
                expect_hi = 0;
                last_end  = cyc;
            end else if (aborted) begin
                last_end = cyc;
            end else begin
                expect_hi = 1;
            end
        end
        if (push) begin
            pcinc_exp = 1;
            pushes++;
`ifdef FETCH_PERF_EN
            if (cnt_exp != 16'hFFFF) cnt_exp++;
`endif
        end
        if (fl) begin
            q.delete();
            last_end = cyc;
        end else begin
            if (push && pop && sz == DEPTH - 1) pp_events++;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.instr = fetch_instr;
                e.addr  = fetch_pc;
                q.push_back(e);
            end
        end

        prev_size = sz;
        req_prev  = pmem_req_o;
        ack_prev  = ack;
        addr_prev = pmem_addr_o;
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        int pc0, pu0, f0, n;

        rst_ni        = 1'b0;
        pc_addr_i     = '0;
        flush_i       = 1'b0;
        pmem_ack_i    = 1'b0;
        pmem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        mem[24'h000000] = 16'h1234;
        mem[24'h000001] = 16'hAB56;

        repeat (2) @(negedge clk_i);
        check("rst_req", 32'(pmem_req_o), 32'd0);
        check("rst_addr", 32'(pmem_addr_o), 32'd0);
        check("rst_pcinc", 32'(pcinc_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", 32'(instr_o), 32'd0);
        check("rst_instr_addr", 32'(instr_addr_o), 32'd0);
        check("rst_fetch_cnt", 32'(fetch_cnt_o), 32'd0);
        rst_ni = 1'b1;

        // First fetch from PC 0 with same-cycle acks, decoder stalled.
        n = 0;
        while (q.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("first_fetch_timeout", 32'(q.size() != 0), 32'd1);
        step();
        check("first_instr", 32'(instr_o), 32'h561234);
        check("first_instr_addr", 32'(instr_addr_o), 32'h000000);
        check("first_pcinc", 32'(pcinc_seen), 32'd1);

        // Stalled decoder: FIFO fills with exactly DEPTH fetches, then fetch stops.
        repeat (40) step();
        check("full_fetches", 32'(fetches), 32'(DEPTH));
        check("full_pcinc", 32'(pcinc_seen), 32'(DEPTH));
        check("full_no_req", 32'(pmem_req_o), 32'd0);
        ready_mode = 1;
        step();
        ready_mode = 0;
        repeat (15) step();
        check("pop_refetch", 32'(fetches), 32'(DEPTH + 1));

        // Three-cycle ack latency on each read.
        ready_mode = 1;
        lat_knob   = 3;
        pc0 = pcinc_seen;
        pu0 = pushes;
        repeat (40) step();
        check("lat3_pcinc", 32'(pcinc_seen - pc0 + int'(pcinc_exp)), 32'(pushes - pu0));

        // Flush while the upper-byte read is outstanding, new PC 0x000200.
        n = 0;
        while (!expect_hi && n < 40) begin
            step();
            n++;
        end
        check("hi_wait_timeout", 32'(expect_hi), 32'd1);
        new_pc     = 24'h000200;
        flush_knob = 1;
        pc0        = pcinc_seen + int'(pcinc_exp);
        repeat (2) step();
        flush_knob = 0;
        f0 = fetches;
        n  = 0;
        while (fetches == f0 && n < 40) begin
            step();
            n++;
        end
        check("flush_refetch_timeout", 32'(fetches != f0), 32'd1);
        check("flush_new_addr", 32'(last_lo), 32'h000200);
        check("flush_no_pcinc", 32'(pcinc_seen), 32'(pc0));

        // Push and pop in the same cycle with one entry buffered; full throughput.
        lat_knob   = 0;
        ready_mode = 2;
        repeat (10) step();
        exact_gap = 1;
        repeat (40) step();
        exact_gap = 0;
        check("push_pop_same_cycle", 32'(pp_events >= 3), 32'd1);

        // Random traffic.
        rand_mode  = 1;
        lat_knob   = -1;
        ready_mode = 3;
        repeat (3000) step();
        rand_mode  = 0;
        flush_left = 0;
        lat_knob   = 0;
        ready_mode = 1;
        repeat (10) step();
        check("total_fetch_cnt", 32'(fetch_cnt_o), 32'(cnt_exp));

        // Asynchronous reset in the middle of a request.
        n = 0;
        while (!pmem_req_o && n < 20) begin
            step();
            n++;
        end
        check("req_wait_timeout", 32'(pmem_req_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_req", 32'(pmem_req_o), 32'd0);
        check("async_rst_valid", 32'(instr_valid_o), 32'd0);
        check("async_rst_instr", 32'(instr_o), 32'd0);
        check("async_rst_fetch_cnt", 32'(fetch_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
